// File: rtl/mem_arb_pkg.sv
// Shared encodings for the IFU/LSU memory arbiter: FSM states, owner ids,
// and the default WAIT timeout.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // Owner id doubles as the bit index into the 2-bit request/grant vectors.
    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and
// moves on every grant.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       gnt_owner
);

    logic last_q, last_d;

    always_comb begin
        gnt       = 2'b00;
        gnt_owner = OWN_IFU;
        last_d    = last_q;
        if (en && (req != 2'b00)) begin
            if (req == 2'b11) begin
                gnt_owner = (last_q == OWN_IFU) ? OWN_LSU : OWN_IFU;
            end else begin
                gnt_owner = req[1] ? OWN_LSU : OWN_IFU;
            end
            gnt    = (gnt_owner == OWN_LSU) ? 2'b10 : 2'b01;
            last_d = gnt_owner;
        end
    end

    // Starting from "IFU last" hands the first tie after reset to the LSU.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_IFU;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and load/store traffic onto one memory port, one
// transaction in flight, with a WAIT-state timeout that aborts with resp_err.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,

    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,

    output logic              mem_req_valid,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        wmask_q, wmask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic       arb_en;
    logic [1:0] gnt;
    logic       gnt_owner;
    logic       resp_pulse;
    logic       tmo_pulse;

    // Gating with rst keeps every grant output low during reset.
    assign arb_en = (state_q == ST_IDLE) && !rst;

    rr_arb2 u_rr_arb2 (
        .clk       (clk),
        .rst       (rst),
        .en        (arb_en),
        .req       ({lsu_req_valid, ifu_req_valid}),
        .gnt       (gnt),
        .gnt_owner (gnt_owner)
    );

    assign ifu_req_ready = gnt[0];
    assign lsu_req_ready = gnt[1];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wen_d      = wen_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        cnt_d      = '0;
        resp_pulse = 1'b0;
        tmo_pulse  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    owner_d = gnt_owner;
                    state_d = ST_REQ;
                    if (gnt_owner == OWN_LSU) begin
                        addr_d  = lsu_addr;
                        wen_d   = lsu_wen;
                        wdata_d = lsu_wdata;
                        wmask_d = lsu_wmask;
                    end else begin
                        addr_d  = ifu_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = 8'h00;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A response landing on the timeout cycle is still a good response.
                if (mem_resp_valid) begin
                    resp_pulse = !rst;
                    state_d    = ST_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    tmo_pulse = !rst;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ifu_resp_valid = (resp_pulse || tmo_pulse) && (owner_q == OWN_IFU);
    assign lsu_resp_valid = (resp_pulse || tmo_pulse) && (owner_q == OWN_LSU);
    assign resp_err       = tmo_pulse;
    assign resp_rdata     = resp_pulse ? mem_rdata : '0;

    assign mem_req_valid  = (state_q == ST_REQ) && !rst;
    assign mem_wen        = rst ? 1'b0 : wen_q;
    assign mem_addr       = rst ? '0   : addr_q;
    assign mem_wdata      = rst ? '0   : wdata_q;
    assign mem_wmask      = rst ? 8'h00 : wmask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IFU;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= 8'h00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
